// File: rtl/da_shift_acc_if.sv
// Handshake bundle between the DA LUT driver and one shift-accumulator channel.
interface da_shift_acc_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 32
);
    logic                   start;
    logic                   partial_valid;
    logic signed [IN_W-1:0] partial_in;
    logic                   busy;
    logic [OUT_W-1:0]       data_out;
    logic                   out_valid;
    logic                   overflow;

    modport master (
        output start, partial_valid, partial_in,
        input  busy, data_out, out_valid, overflow
    );

    modport slave (
        input  start, partial_valid, partial_in,
        output busy, data_out, out_valid, overflow
    );
endinterface

// File: rtl/da_shift_acc.sv
// Bit-serial DA shift-accumulator, MSB (sign) plane first, with an enabled output register.
// Latency: out_valid/data_out appear the cycle after the last beat; back-to-back period BITS+1.
// Backpressure: partial_valid low stalls the accumulation; optional clamp via DA_ACC_SAT_EN.
module da_shift_acc #(
    parameter int IN_W    = 32,
    parameter int BITS    = 16,
    parameter int OUT_W   = 32,
    parameter int OUT_LSB = 0
) (
    input  logic          clk,
    input  logic          rst,
    da_shift_acc_if.slave bus
);
    localparam int ACC_W = IN_W + BITS;
    localparam int CNT_W = $clog2(BITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BITS - 1);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] p_ext;
    logic [OUT_W-1:0]        res;
    logic                    res_ovf;
    logic [OUT_W-1:0]        data_q;
    logic                    ovf_q;
    logic                    vld_q;
    logic                    busy_q;

    assign p_ext    = {{BITS{bus.partial_in[IN_W-1]}}, bus.partial_in};
    // The sign plane carries negative weight, so it seeds the accumulator negated.
    assign acc_next = (cnt == '0) ? -p_ext : (acc <<< 1) + p_ext;

`ifdef DA_ACC_SAT_EN
    logic signed [ACC_W-1:0] shifted;
    logic signed [ACC_W-1:0] hi;

    assign shifted = acc_next >>> OUT_LSB;
    // Fits in OUT_W signed only when everything above the output sign bit is a sign copy.
    assign hi      = shifted >>> (OUT_W - 1);
    assign res_ovf = !((hi == '0) || (hi == '1));

    always_comb begin
        res = shifted[OUT_W-1:0];
        if (res_ovf)
            res = acc_next[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
`else
    assign res     = acc_next[OUT_LSB +: OUT_W];
    assign res_ovf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            data_q <= '0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= ACC;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ACC: begin
                    if (bus.partial_valid) begin
                        acc <= acc_next;
                        if (cnt == LAST) begin
                            // Output register loads here so the result is visible during DONE.
                            state  <= DONE;
                            busy_q <= 1'b0;
                            vld_q  <= 1'b1;
                            data_q <= res;
                            ovf_q  <= res_ovf;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state  <= ACC;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.data_out  = data_q;
    assign bus.out_valid = vld_q;
    assign bus.overflow  = ovf_q;
endmodule
